// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle core sequencer: state codes, opcode classes,
// PC/write-back mux selects and the bundled control word.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    OP_RTYPE   = 4'd0,
    OP_ITYPE   = 4'd1,
    OP_LW      = 4'd2,
    OP_SW      = 4'd3,
    OP_BEQ     = 4'd4,
    OP_BNE     = 4'd5,
    OP_J       = 4'd6,
    OP_JAL     = 4'd7,
    OP_RET     = 4'd8,
    OP_ILLEGAL = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4  = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_JUMP   = 2'd2,
    PC_SRC_REG    = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic    pc_write;
    pc_src_e pc_src;
    logic    ir_write;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    wb_sel_e wb_sel;
    logic    alu_src_b;
    logic    instr_done;
  } ctrl_t;

  // Any raw opcode outside 0..8 collapses to OP_ILLEGAL and executes as a NOP.
  function automatic opcode_e decode_opcode(input logic [31:0] raw);
    case (raw)
      32'd0:   return OP_RTYPE;
      32'd1:   return OP_ITYPE;
      32'd2:   return OP_LW;
      32'd3:   return OP_SW;
      32'd4:   return OP_BEQ;
      32'd5:   return OP_BNE;
      32'd6:   return OP_J;
      32'd7:   return OP_JAL;
      32'd8:   return OP_RET;
      default: return OP_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_decoder.sv
// Purely combinational decode of (state, opcode, zero, mem_ready) into the
// strobes and mux selects of the multicycle datapath.
module control_output_decoder
  import multicycle_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  state_e              state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output ctrl_t               ctrl_o
);

  opcode_e op;
  assign op = decode_opcode(32'(opcode_i));

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_IF: begin
        ctrl_o.mem_read = 1'b1;
        if (mem_ready_i) begin
          ctrl_o.ir_write = 1'b1;
          ctrl_o.pc_write = 1'b1;
          ctrl_o.pc_src   = PC_SRC_PLUS4;
        end
      end
      S_ID: begin
        case (op)
          OP_J, OP_JAL: begin
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.pc_src     = PC_SRC_JUMP;
            ctrl_o.instr_done = 1'b1;
            if (op == OP_JAL) begin
              ctrl_o.reg_write = 1'b1;
              ctrl_o.wb_sel    = WB_SEL_PC4;
            end
          end
          OP_RET: begin
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.pc_src     = PC_SRC_REG;
            ctrl_o.instr_done = 1'b1;
          end
          OP_ILLEGAL: ctrl_o.instr_done = 1'b1;
          default: ;
        endcase
      end
      S_EX: begin
        ctrl_o.alu_src_b = (op == OP_ITYPE) || (op == OP_LW) || (op == OP_SW);
        if ((op == OP_BEQ) || (op == OP_BNE)) begin
          ctrl_o.pc_write   = (op == OP_BEQ) ? zero_i : ~zero_i;
          ctrl_o.pc_src     = PC_SRC_BRANCH;
          ctrl_o.instr_done = 1'b1;
        end
      end
      S_MEM: begin
        // Request is held for every waiting cycle, not just the first.
        ctrl_o.mem_read   = (op == OP_LW);
        ctrl_o.mem_write  = (op == OP_SW);
        ctrl_o.instr_done = (op == OP_SW) && mem_ready_i;
      end
      S_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.wb_sel     = (op == OP_LW) ? WB_SEL_MEM : WB_SEL_ALU;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main IF/ID/EX/MEM/WB sequencer. Defining MULTICYCLE_PERF_COUNTERS_EN adds
// cycle_count/instr_count performance counter ports.
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                alu_src_b,
  output logic                instr_done
`ifdef MULTICYCLE_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instr_count
`endif
);

  // Memory handshake: mem_read/mem_write is a request that stays high in IF/MEM
  // until the cycle mem_ready is 1; the transfer completes on that clock edge.
  state_e  state_q, state_d;
  opcode_e op;
  ctrl_t   dec_ctrl, ctrl;

  assign op = decode_opcode(32'(opcode));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: if (mem_ready) state_d = S_ID;
      S_ID: begin
        case (op)
          OP_J, OP_JAL, OP_RET, OP_ILLEGAL: state_d = S_IF;
          default:                          state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (op)
          OP_RTYPE, OP_ITYPE: state_d = S_WB;
          OP_LW, OP_SW:       state_d = S_MEM;
          default:            state_d = S_IF;
        endcase
      end
      S_MEM: if (mem_ready) state_d = (op == OP_LW) ? S_WB : S_IF;
      default: state_d = S_IF;
    endcase
  end

  control_output_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
    .state_i    (state_q),
    .opcode_i   (opcode),
    .zero_i     (zero),
    .mem_ready_i(mem_ready),
    .ctrl_o     (dec_ctrl)
  );

  // Reset must abort an in-flight access in the same cycle, so it masks outputs directly.
  assign ctrl       = reset ? '0 : dec_ctrl;
  assign state      = state_q;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign ir_write   = ctrl.ir_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign wb_sel     = ctrl.wb_sel;
  assign alu_src_b  = ctrl.alu_src_b;
  assign instr_done = ctrl.instr_done;

`ifdef MULTICYCLE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_count_q, instr_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_q + CNT_W'(1);
      if (dec_ctrl.instr_done) instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: each instruction is expanded into
// an expected per-cycle phase list from the instruction rules and compared cycle by cycle.
module tb_multicycle_control_fsm;
  localparam int OPCODE_W = 6;
  localparam int CNT_W    = 32;

  logic                clk = 1'b0;
  logic                reset, zero, mem_ready;
  logic [OPCODE_W-1:0] opcode;
  logic [2:0]          state;
  logic                pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_b, instr_done;
  logic [1:0]          pc_src, wb_sel;
`ifdef MULTICYCLE_PERF_COUNTERS_EN
  logic [CNT_W-1:0]    cycle_count, instr_count;
`endif

  int total = 0;
  int bad   = 0;
  // {mem_ready to drive, state[2:0], pc_write, pc_src[1:0], ir_write, mem_read,
  //  mem_write, reg_write, wb_sel[1:0], alu_src_b, instr_done}
  logic [14:0] exp_q[$];
  int cyc_exp = 0;
  int ins_exp = 0;
  int lat_seen, cyc_in_instr;

  wire [10:0] ctrl_vec = {pc_write, pc_src, ir_write, mem_read, mem_write,
                          reg_write, wb_sel, alu_src_b, instr_done};

  multicycle_control_fsm #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .state     (state),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_b (alu_src_b),
    .instr_done(instr_done)
`ifdef MULTICYCLE_PERF_COUNTERS_EN
    ,
    .cycle_count(cycle_count),
    .instr_count(instr_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [14:0] mk(input bit rdy, input int st, input bit pw, input int ps,
                                     input bit iw, input bit mr, input bit mw, input bit rw,
                                     input int wb, input bit ab, input bit d);
    return {rdy, 3'(st), pw, 2'(ps), iw, mr, mw, rw, 2'(wb), ab, d};
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  // ---------------- reference model ----------------
  function automatic int latency_of(input int op, input int w_if, input int w_mem);
    if (op >= 6 || op < 0) return 2 + w_if;
    if (op == 4 || op == 5) return 3 + w_if;
    if (op == 2)            return 5 + w_if + w_mem;
    return 4 + w_if + ((op == 3) ? w_mem : 0);
  endfunction

  task automatic build_expect(input int op, input bit z, input int w_if, input int w_mem);
    bit ab;
    for (int i = 0; i < w_if; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    if (op == 6) begin exp_q.push_back(mk(rnd_bit(), 1, 1, 2, 0, 0, 0, 0, 0, 0, 1)); return; end
    if (op == 7) begin exp_q.push_back(mk(rnd_bit(), 1, 1, 2, 0, 0, 0, 1, 2, 0, 1)); return; end
    if (op == 8) begin exp_q.push_back(mk(rnd_bit(), 1, 1, 3, 0, 0, 0, 0, 0, 0, 1)); return; end
    if (op > 8)  begin exp_q.push_back(mk(rnd_bit(), 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); return; end
    exp_q.push_back(mk(rnd_bit(), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (op == 4) begin exp_q.push_back(mk(rnd_bit(), 2, z, 1, 0, 0, 0, 0, 0, 0, 1)); return; end
    if (op == 5) begin exp_q.push_back(mk(rnd_bit(), 2, !z, 1, 0, 0, 0, 0, 0, 0, 1)); return; end
    ab = (op == 1) || (op == 2) || (op == 3);
    exp_q.push_back(mk(rnd_bit(), 2, 0, 0, 0, 0, 0, 0, 0, ab, 0));
    if (op == 2 || op == 3) begin
      for (int i = 0; i < w_mem; i++) exp_q.push_back(mk(0, 3, 0, 0, 0, op == 2, op == 3, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 3, 0, 0, 0, op == 2, op == 3, 0, 0, 0, op == 3));
      if (op == 3) return;
    end
    exp_q.push_back(mk(rnd_bit(), 4, 0, 0, 0, 0, 0, 1, (op == 2) ? 1 : 0, 0, 1));
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic [14:0] e);
    mem_ready = e[14];
    @(negedge clk);
    check("state", 32'(state), 32'(e[13:11]));
    check("ctrl", 32'(ctrl_vec), 32'(e[10:0]));
    cyc_in_instr++;
    if (instr_done && lat_seen == 0) lat_seen = cyc_in_instr;
    cyc_exp++;
    if (e[0]) ins_exp++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int op, input bit z, input int w_if, input int w_mem);
    opcode = OPCODE_W'(op);
    zero   = z;
    exp_q.delete();
    build_expect(op, z, w_if, w_mem);
    lat_seen     = 0;
    cyc_in_instr = 0;
    while (exp_q.size() > 0) do_cycle(exp_q.pop_front());
    check("latency", 32'(lat_seen), 32'(latency_of(op, w_if, w_mem)));
  endtask

  task automatic check_counters();
`ifdef MULTICYCLE_PERF_COUNTERS_EN
    check("cycle_count", cycle_count, 32'(cyc_exp));
    check("instr_count", instr_count, 32'(ins_exp));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    int sel;
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(ctrl_vec), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; cyc_exp = 0; ins_exp = 0;

    // Back-to-back RTYPE, LW, J: 4 + 5 + 2 cycles.
    run_instr(0, 0, 0, 0);
    run_instr(2, 0, 0, 0);
    run_instr(6, 0, 0, 0);
    check_counters();

    run_instr(2, 0, 0, 3);
    run_instr(4, 1, 0, 0);
    run_instr(5, 1, 0, 0);
    run_instr(7, 0, 0, 0);
    run_instr(63, 0, 0, 0);
    run_instr(1, 0, 2, 0);
    run_instr(3, 0, 1, 2);
    run_instr(8, 1, 0, 0);
    run_instr(4, 0, 0, 0);
    run_instr(5, 0, 0, 0);
    run_instr(9, 1, 1, 0);

    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 11));
      if (sel <= 8)       op = sel;
      else if (sel == 9)  op = 63;
      else                op = int'($urandom_range(9, 63));
      run_instr(op, rnd_bit(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    check_counters();

    // Reset while an SW is stalled in MEM.
    opcode = OPCODE_W'(3); zero = 1'b0;
    exp_q.delete();
    build_expect(3, 0, 0, 3);
    lat_seen = 0; cyc_in_instr = 0;
    for (int i = 0; i < 4; i++) do_cycle(exp_q.pop_front());
    exp_q.delete();
    reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_state", 32'(state), 32'd3);
    check("rst_mid_ctrl", 32'(ctrl_vec), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_state2", 32'(state), 32'd0);
    check("rst_mid_ctrl2", 32'(ctrl_vec), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; cyc_exp = 0; ins_exp = 0;
    run_instr(0, 0, 1, 0);
    run_instr(3, 1, 0, 1);
    run_instr(7, 0, 0, 0);
    check_counters();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
